chess_timer_ctrl: RTL and testbench
===================================

// Module: chess_timer_ctrl
// PURPOSE
//  Game controller for the chess clock. Holds two BCD mm:ss countdown timers (player A, player B),
//  runs whichever player is on move and passes the turn on that player's button press.
//  Detects time-out and drives over/win straight into seg_dis (over->en, win->win).
//  Also exports both timers and the run flags to the digit display stage.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per timer second (>=2)
//  INIT_MIN  10           starting minutes per player, 1..99, loaded as BCD mm, ss=00
// PORTS
//  clk        in   1   system clock, all flops on rising edge
//  rst_n      in   1   asynchronous reset, active-low
//  btn_start  in   1   debounced level, start / new game
//  btn_a      in   1   debounced level, player A ends move
//  btn_b      in   1   debounced level, player B ends move
//  time_a     out  16  player A time, BCD {m_tens,m_units,s_tens,s_units}
//  time_b     out  16  player B time, same format
//  run_a      out  1   1 while A's clock runs
//  run_b      out  1   1 while B's clock runs
//  over       out  1   game finished (seg_dis en)
//  win        out  1   1 = player A wins, 0 = player B wins; valid while over=1
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, time_a=time_b={BCD(INIT_MIN),8'h00}, run_a=run_b=0,
//   over=0, win=0, prescaler=0, synchronisers=0. Reset mid-game aborts immediately.
//  Inputs: each btn goes through a 2-flop synchroniser plus a previous-value flop.
//   press = sync2 & ~prev. Input high before edge k -> action at edge k+2. Held buttons act once.
//  FSM (all outputs registered):
//   IDLE : start -> RUN_A (A moves first). btn_a/btn_b ignored.
//   RUN_A: press_a -> RUN_B. Time-out of A -> OVER, win=0. press_b and press_start ignored.
//   RUN_B: press_b -> RUN_A. Time-out of B -> OVER, win=1. press_a and press_start ignored.
//   OVER : timers frozen, over=1, win held. start -> reload both timers to init, go to IDLE,
//          over=0, win=0.
//   run_a=1 only in RUN_A. run_b=1 only in RUN_B.
//  Prescaler:
//   Counts 0..TICK_DIV-1 only in RUN_A/RUN_B. tick = (count==TICK_DIV-1); count wraps to 0 on tick.
//   Cleared on every turn change and in IDLE/OVER.
//  Tick:
//   Decrements the active player's timer by 1 s in BCD. Borrow chain:
//    s_units 0->9, borrow; s_tens 0->5, borrow; m_units 0->9, borrow; m_tens--.
//   Never decrements below 0000.
//   A tick taking the timer 0001->0000 also moves the FSM to OVER on the same edge.
//  Simultaneous active-player press and tick: the press wins. No decrement that cycle,
//   the turn switches, and the prescaler clears.
//  Simultaneous press_a and press_b: only the active player's press is honoured.
//  The idle player's timer never changes while the other player runs.
// TESTING  (TICK_DIV=4, INIT_MIN=1)
//  1 reset, 100 cycles idle -> time_a=time_b=16'h0100, run_a=run_b=over=win=0.
//  2 start pulse, then 4 cycles -> run_a=1, time_a=16'h0059, time_b=16'h0100.
//    Hold btn_a high 20 cycles -> exactly one switch to run_b; then only time_b decrements.
//  3 in RUN_A pulse btn_b -> ignored, run_a stays 1. Pulse btn_a and btn_b together -> RUN_B.
//  4 run A for 60 ticks -> time_a=16'h0000, over=1, win=0, run_a=0. Timers then frozen 50 cycles.
//    Repeat for B -> over=1, win=1.
//  5 time_a=16'h0001, btn_a press aligned to the tick edge -> RUN_B, time_a stays 0001, over=0.
//    Also check BCD borrow 16'h1000 -> 16'h0959 with INIT_MIN=10.
//  6 rst_n low mid RUN_B -> all outputs at reset values immediately (async).
//    In OVER, start press -> IDLE, timers 16'h0100, over=0.

Source files
------------

// File: rtl/chess_timer_ctrl.sv
// Chess clock game controller: two BCD mm:ss countdown timers, turn passing on
// synchronised button presses, and time-out detection feeding the display stage.
module chess_timer_ctrl #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned INIT_MIN = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_a,
  input  logic        btn_b,
  output logic [15:0] time_a,
  output logic [15:0] time_b,
  output logic        run_a,
  output logic        run_b,
  output logic        over,
  output logic        win
);

  localparam int unsigned    CW        = (TICK_DIV > 32'd1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 32'd1);
  localparam logic [15:0]    INIT_TIME = {4'(INIT_MIN / 32'd10), 4'(INIT_MIN % 32'd10), 8'h00};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN_A = 2'd1,
    S_RUN_B = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  // One-second BCD decrement with borrow chain, saturating at 00:00.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (t == 16'h0000) begin
      return t;
    end else if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    r_prev;
  logic [2:0]    w_press;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_tick;
  logic [15:0]   r_time_a;
  logic [15:0]   r_time_b;
  logic [15:0]   w_time_a_nxt;
  logic [15:0]   w_time_b_nxt;
  logic          r_run_a;
  logic          r_run_b;
  logic          r_over;
  logic          r_win;
  logic          w_win_nxt;

  // Button synchronisers plus previous-value flops, bit order {start, b, a}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
      r_prev  <= 3'b000;
    end else begin
      r_sync1 <= {btn_start, btn_b, btn_a};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_press = r_sync2 & ~r_prev;
  assign w_tick  = (r_cnt == TICK_LAST);

  // Next-state, timer and prescaler logic; a press always beats a coincident tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = {CW{1'b0}};
    w_time_a_nxt = r_time_a;
    w_time_b_nxt = r_time_b;
    w_win_nxt    = r_win;
    case (r_state)
      S_IDLE: begin
        if (w_press[2]) begin
          w_state_nxt = S_RUN_A;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN_A: begin
        if (w_press[0]) begin
          w_state_nxt = S_RUN_B;
        end else if (w_tick) begin
          w_time_a_nxt = bcd_dec(r_time_a);
          if (r_time_a <= 16'h0001) begin
            w_state_nxt = S_OVER;
            w_win_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_RUN_A;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RUN_B: begin
        if (w_press[1]) begin
          w_state_nxt = S_RUN_A;
        end else if (w_tick) begin
          w_time_b_nxt = bcd_dec(r_time_b);
          if (r_time_b <= 16'h0001) begin
            w_state_nxt = S_OVER;
            w_win_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_RUN_B;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_OVER: begin
        if (w_press[2]) begin
          w_state_nxt  = S_IDLE;
          w_time_a_nxt = INIT_TIME;
          w_time_b_nxt = INIT_TIME;
          w_win_nxt    = 1'b0;
        end else begin
          w_state_nxt = S_OVER;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, timers and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_time_a <= INIT_TIME;
      r_time_b <= INIT_TIME;
      r_run_a  <= 1'b0;
      r_run_b  <= 1'b0;
      r_over   <= 1'b0;
      r_win    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_time_a <= w_time_a_nxt;
      r_time_b <= w_time_b_nxt;
      r_run_a  <= (w_state_nxt == S_RUN_A);
      r_run_b  <= (w_state_nxt == S_RUN_B);
      r_over   <= (w_state_nxt == S_OVER);
      r_win    <= w_win_nxt;
    end
  end

  assign time_a = r_time_a;
  assign time_b = r_time_b;
  assign run_a  = r_run_a;
  assign run_b  = r_run_b;
  assign over   = r_over;
  assign win    = r_win;

endmodule

// File: tb/tb_chess_timer_ctrl.sv
// Bench for chess_timer_ctrl: directed vector table, hand-written corner sequences,
// then random button activity checked against a seconds-based game model.
module tb_chess_timer_ctrl;

  localparam int TICK_DIV = 4;
  localparam int INIT_MIN = 1;
  localparam int M_IDLE = 0, M_RUN_A = 1, M_RUN_B = 2, M_OVER = 3;

  logic        clk;
  logic        rst_n;
  logic        s_in, a_in, b_in;
  logic [15:0] time_a, time_b;
  logic        run_a, run_b, over, win;
  logic        s10, a10, b10;
  logic [15:0] time_a10, time_b10;
  logic        run_a10, run_b10, over10, win10;

  int n_tests = 0;
  int n_fail  = 0;

  chess_timer_ctrl #(.TICK_DIV(TICK_DIV), .INIT_MIN(INIT_MIN)) dut (
    .clk(clk), .rst_n(rst_n), .btn_start(s_in), .btn_a(a_in), .btn_b(b_in),
    .time_a(time_a), .time_b(time_b), .run_a(run_a), .run_b(run_b),
    .over(over), .win(win)
  );

  chess_timer_ctrl #(.TICK_DIV(TICK_DIV), .INIT_MIN(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .btn_start(s10), .btn_a(a10), .btn_b(b10),
    .time_a(time_a10), .time_b(time_b10), .run_a(run_a10), .run_b(run_b10),
    .over(over10), .win(win10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  in;   // {start, a, b}
    int          n;
    logic [35:0] exp;  // {time_a, time_b, run_a, run_b, over, win}
  } vec_t;

  vec_t vt[$];

  // Game model: times kept as plain seconds, buttons as raw input history.
  int   m_mode, m_sa, m_sb, m_cyc;
  logic m_win;
  logic hs[4], ha[4], hb[4];

  function automatic vec_t mk(input string nm, input logic [2:0] in, input int n,
                              input logic [35:0] e);
    vec_t v;
    v.name = nm; v.in = in; v.n = n; v.exp = e;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [35:0] pack_main();
    return {time_a, time_b, run_a, run_b, over, win};
  endfunction

  function automatic logic [35:0] pack_10();
    return {time_a10, time_b10, run_a10, run_b10, over10, win10};
  endfunction

  function automatic logic [35:0] model_pack();
    return {to_bcd(m_sa), to_bcd(m_sb), m_mode == M_RUN_A, m_mode == M_RUN_B,
            m_mode == M_OVER, m_win};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_sa   = INIT_MIN * 60;
    m_sb   = INIT_MIN * 60;
    m_cyc  = 0;
    m_win  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hs[i] = 1'b0; ha[i] = 1'b0; hb[i] = 1'b0;
    end
  endtask

  // A button high before edge k acts at edge k+2, once per rising level.
  task automatic model_step();
    logic ps, pa, pb;
    for (int i = 3; i > 0; i--) begin
      hs[i] = hs[i-1]; ha[i] = ha[i-1]; hb[i] = hb[i-1];
    end
    hs[0] = s_in; ha[0] = a_in; hb[0] = b_in;
    ps = hs[2] & ~hs[3];
    pa = ha[2] & ~ha[3];
    pb = hb[2] & ~hb[3];
    case (m_mode)
      M_IDLE: if (ps) begin m_mode = M_RUN_A; m_cyc = 0; end
      M_RUN_A: begin
        if (pa) begin
          m_mode = M_RUN_B; m_cyc = 0;
        end else begin
          m_cyc++;
          if (m_cyc == TICK_DIV) begin
            m_cyc = 0;
            if (m_sa > 0) m_sa--;
            if (m_sa == 0) begin m_mode = M_OVER; m_win = 1'b0; end
          end
        end
      end
      M_RUN_B: begin
        if (pb) begin
          m_mode = M_RUN_A; m_cyc = 0;
        end else begin
          m_cyc++;
          if (m_cyc == TICK_DIV) begin
            m_cyc = 0;
            if (m_sb > 0) m_sb--;
            if (m_sb == 0) begin m_mode = M_OVER; m_win = 1'b1; end
          end
        end
      end
      M_OVER: begin
        if (ps) begin
          m_mode = M_IDLE;
          m_sa   = INIT_MIN * 60;
          m_sb   = INIT_MIN * 60;
          m_win  = 1'b0;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ta=%h tb=%h ra/rb/over/win=%b, want ta=%h tb=%h ra/rb/over/win=%b",
               name, got[35:20], got[19:4], got[3:0], exp[35:20], exp[19:4], exp[3:0]);
    end
  endtask

  initial begin
    int len;

    vt.push_back(mk("idle100",          3'b000, 100, {16'h0100, 16'h0100, 4'b0000}));
    vt.push_back(mk("start_hi",         3'b100, 1,   {16'h0100, 16'h0100, 4'b0000}));
    vt.push_back(mk("start_sync",       3'b000, 1,   {16'h0100, 16'h0100, 4'b0000}));
    vt.push_back(mk("start_go",         3'b000, 1,   {16'h0100, 16'h0100, 4'b1000}));
    vt.push_back(mk("run_a_pre",        3'b000, 3,   {16'h0100, 16'h0100, 4'b1000}));
    vt.push_back(mk("run_a_tick",       3'b000, 1,   {16'h0059, 16'h0100, 4'b1000}));
    vt.push_back(mk("hold_a",           3'b010, 20,  {16'h0059, 16'h0056, 4'b0100}));
    vt.push_back(mk("release_a",        3'b000, 8,   {16'h0059, 16'h0054, 4'b0100}));
    vt.push_back(mk("b_hi",             3'b001, 1,   {16'h0059, 16'h0054, 4'b0100}));
    vt.push_back(mk("press_beats_tick", 3'b000, 2,   {16'h0059, 16'h0054, 4'b1000}));
    vt.push_back(mk("b_ign_hi",         3'b001, 1,   {16'h0059, 16'h0054, 4'b1000}));
    vt.push_back(mk("b_ignored",        3'b000, 3,   {16'h0058, 16'h0054, 4'b1000}));
    vt.push_back(mk("ab_hi",            3'b011, 1,   {16'h0058, 16'h0054, 4'b1000}));
    vt.push_back(mk("ab_switch",        3'b000, 2,   {16'h0058, 16'h0054, 4'b0100}));
    vt.push_back(mk("b_run",            3'b000, 215, {16'h0058, 16'h0001, 4'b0100}));
    vt.push_back(mk("b_timeout",        3'b000, 1,   {16'h0058, 16'h0000, 4'b0011}));
    vt.push_back(mk("b_frozen",         3'b000, 50,  {16'h0058, 16'h0000, 4'b0011}));
    vt.push_back(mk("ab_over_hi",       3'b011, 1,   {16'h0058, 16'h0000, 4'b0011}));
    vt.push_back(mk("ab_over_ign",      3'b000, 3,   {16'h0058, 16'h0000, 4'b0011}));
    vt.push_back(mk("st_over_hi",       3'b100, 1,   {16'h0058, 16'h0000, 4'b0011}));
    vt.push_back(mk("st_over_sync",     3'b000, 1,   {16'h0058, 16'h0000, 4'b0011}));
    vt.push_back(mk("st_over_idle",     3'b000, 1,   {16'h0100, 16'h0100, 4'b0000}));
    vt.push_back(mk("st2_hi",           3'b100, 1,   {16'h0100, 16'h0100, 4'b0000}));
    vt.push_back(mk("st2_go",           3'b000, 2,   {16'h0100, 16'h0100, 4'b1000}));
    vt.push_back(mk("a_run",            3'b000, 239, {16'h0001, 16'h0100, 4'b1000}));
    vt.push_back(mk("a_timeout",        3'b000, 1,   {16'h0000, 16'h0100, 4'b0010}));
    vt.push_back(mk("a_frozen",         3'b000, 50,  {16'h0000, 16'h0100, 4'b0010}));
    vt.push_back(mk("st3_hi",           3'b100, 1,   {16'h0000, 16'h0100, 4'b0010}));
    vt.push_back(mk("st3_idle",         3'b000, 2,   {16'h0100, 16'h0100, 4'b0000}));
    vt.push_back(mk("st4_hi",           3'b100, 1,   {16'h0100, 16'h0100, 4'b0000}));
    vt.push_back(mk("st4_go",           3'b000, 2,   {16'h0100, 16'h0100, 4'b1000}));
    vt.push_back(mk("a_run59",          3'b000, 236, {16'h0001, 16'h0100, 4'b1000}));
    vt.push_back(mk("align_pre",        3'b000, 1,   {16'h0001, 16'h0100, 4'b1000}));
    vt.push_back(mk("align_hi",         3'b010, 1,   {16'h0001, 16'h0100, 4'b1000}));
    vt.push_back(mk("align_press_tick", 3'b000, 2,   {16'h0001, 16'h0100, 4'b0100}));
    vt.push_back(mk("b_after_align",    3'b000, 4,   {16'h0001, 16'h0059, 4'b0100}));

    rst_n = 1'b0;
    s_in = 1'b0; a_in = 1'b0; b_in = 1'b0;
    s10 = 1'b0; a10 = 1'b0; b10 = 1'b0;
    model_reset();
    #12;
    check("reset", pack_main(), {16'h0100, 16'h0100, 4'b0000});
    check("reset10", pack_10(), {16'h1000, 16'h1000, 4'b0000});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // BCD borrow across minutes on the 10-minute instance.
    s10 = 1'b1;
    step();
    s10 = 1'b0;
    step();
    step();
    check("run10", pack_10(), {16'h1000, 16'h1000, 4'b1000});
    repeat (4) step();
    check("borrow10", pack_10(), {16'h0959, 16'h1000, 4'b1000});
    repeat (4) step();
    check("dec10", pack_10(), {16'h0958, 16'h1000, 4'b1000});

    foreach (vt[i]) begin
      {s_in, a_in, b_in} = vt[i].in;
      repeat (vt[i].n) step();
      check(vt[i].name, pack_main(), vt[i].exp);
    end

    // Asynchronous reset mid RUN_B, well away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", pack_main(), {16'h0100, 16'h0100, 4'b0000});
    model_reset();
    #2;
    rst_n = 1'b1;

    for (int seg = 0; seg < 160; seg++) begin
      if ($urandom_range(0, 5) == 0) begin
        s_in = 1'b0; a_in = 1'b0; b_in = 1'b0;
        len = int'($urandom_range(100, 300));
      end else begin
        s_in = ($urandom_range(0, 7) == 0);
        a_in = ($urandom_range(0, 2) == 0);
        b_in = ($urandom_range(0, 2) == 0);
        len = int'($urandom_range(1, 12));
      end
      for (int c = 0; c < len; c++) begin
        step();
        check("random", pack_main(), model_pack());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
